// File: rtl/algo_rbnk_refr_sched.sv
// Refresh scheduler for the bank array: collects refresh credits from a period timer or an
// external strobe, then issues one refresh per credit, round-robin over the refresh banks.
module algo_rbnk_refr_sched #(
    parameter int NUMRBNK = 4,
    parameter int BITRBNK = 2,
    parameter int REFFREQ = 6,
    parameter int REFFRHF = 0,
    parameter int EXTREF  = 0,
    parameter int MAXPEND = 4,
    parameter int URGENT  = 3,
    parameter int BITPEND = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic               refr,
    input  logic               hold,
    output logic               refr_vld,
    output logic [BITRBNK-1:0] refr_bank,
    output logic               stall,
    output logic [BITPEND-1:0] pend_cnt,
    output logic               ovfl
);

    localparam int   BITTMR = $clog2(REFFREQ + 2);
    localparam logic HFEN   = (REFFRHF != 0);
    localparam logic EXTEN  = (EXTREF != 0);

    logic [BITTMR-1:0]  tmrCnt, tmrNext, tmrLast;
    logic               halfTgl, halfNext;
    logic [BITRBNK-1:0] bankPtr, ptrNext;
    logic [BITPEND-1:0] pendNext;
    logic               tick, add, issue, atMax, dropNow, stallNext;

    // Odd periods are one cycle longer when the half-period option is on.
    always_comb begin
        tmrLast = BITTMR'(REFFREQ - 1) + {{(BITTMR-1){1'b0}}, (HFEN & halfTgl)};
        tick    = !EXTEN & ready & (tmrCnt == tmrLast);
        add     = EXTEN ? (ready & refr) : tick;
        issue   = ready & (pend_cnt != '0) & (!hold | stall);
        atMax   = (pend_cnt == BITPEND'(MAXPEND));
        dropNow = add & !issue & atMax;
    end

    always_comb begin
        pendNext = pend_cnt;
        if (!ready) begin
            pendNext = '0;
        end else if (add && !issue && !atMax) begin
            pendNext = pend_cnt + BITPEND'(1);
        end else if (!add && issue) begin
            pendNext = pend_cnt - BITPEND'(1);
        end
        stallNext = ready & (pend_cnt >= BITPEND'(URGENT));
    end

    always_comb begin
        ptrNext = bankPtr;
        if (issue) begin
            ptrNext = (bankPtr == BITRBNK'(NUMRBNK - 1)) ? '0 : bankPtr + BITRBNK'(1);
        end
    end

    always_comb begin
        tmrNext  = tmrCnt;
        halfNext = halfTgl;
        if (!ready || EXTEN) begin
            tmrNext  = '0;
            halfNext = 1'b0;
        end else if (tick) begin
            tmrNext  = '0;
            halfNext = HFEN & !halfTgl;
        end else begin
            tmrNext  = tmrCnt + BITTMR'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmrCnt    <= '0;
            halfTgl   <= 1'b0;
            bankPtr   <= '0;
            pend_cnt  <= '0;
            refr_vld  <= 1'b0;
            refr_bank <= '0;
            stall     <= 1'b0;
            ovfl      <= 1'b0;
        end else begin
            tmrCnt   <= tmrNext;
            halfTgl  <= halfNext;
            bankPtr  <= ptrNext;
            pend_cnt <= pendNext;
            refr_vld <= issue;
            stall    <= stallNext;
            if (issue) begin
                refr_bank <= bankPtr;
            end
            if (dropNow) begin
                ovfl <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_algo_rbnk_refr_sched.sv
// Self-checking bench: three scheduler variants share stimulus and are compared every cycle
// against a rule-level model, plus directed cycle checks of the documented scenarios.
module tb_algo_rbnk_refr_sched;

    logic clk = 1'b0;
    logic rst, ready, refr, hold;
    logic       vldO   [3];
    logic [1:0] bankO  [3];
    logic       stallO [3];
    logic [2:0] pendO  [3];
    logic       ovflO  [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Variant table: 0 = defaults, 1 = half-period timer, 2 = external credits, URGENT=4.
    int pHf  [3] = '{0, 1, 0};
    int pExt [3] = '{0, 0, 1};
    int pUrg [3] = '{3, 3, 4};
    localparam int FREQ = 6, MAXP = 4, NBANK = 4;

    int mTmr [3], mTicks [3], mPend [3], mPtr [3], mVld [3], mBank [3], mStall [3], mOvfl [3];

    always #5 clk = ~clk;

    algo_rbnk_refr_sched dutA (
        .clk(clk), .rst(rst), .ready(ready), .refr(refr), .hold(hold),
        .refr_vld(vldO[0]), .refr_bank(bankO[0]), .stall(stallO[0]), .pend_cnt(pendO[0]),
        .ovfl(ovflO[0])
    );

    algo_rbnk_refr_sched #(.REFFRHF(1)) dutB (
        .clk(clk), .rst(rst), .ready(ready), .refr(refr), .hold(hold),
        .refr_vld(vldO[1]), .refr_bank(bankO[1]), .stall(stallO[1]), .pend_cnt(pendO[1]),
        .ovfl(ovflO[1])
    );

    algo_rbnk_refr_sched #(.EXTREF(1), .URGENT(4)) dutC (
        .clk(clk), .rst(rst), .ready(ready), .refr(refr), .hold(hold),
        .refr_vld(vldO[2]), .refr_bank(bankO[2]), .stall(stallO[2]), .pend_cnt(pendO[2]),
        .ovfl(ovflO[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mTmr[k] = 0; mTicks[k] = 0; mPend[k] = 0; mPtr[k] = 0;
            mVld[k] = 0; mBank[k] = 0; mStall[k] = 0; mOvfl[k] = 0;
        end
    endtask

    // One cycle of the scheduling rules, from current model state and this cycle's inputs.
    task automatic modelStep(input int k, input int rd, input int rf, input int hd);
        int period, add, iss;
        period = FREQ + ((pHf[k] != 0 && (mTicks[k] % 2) == 1) ? 1 : 0);
        if (pExt[k] != 0) add = (rd != 0 && rf != 0) ? 1 : 0;
        else              add = (rd != 0 && mTmr[k] == period - 1) ? 1 : 0;
        iss = (rd != 0 && mPend[k] > 0 && (hd == 0 || mStall[k] != 0)) ? 1 : 0;
        mVld[k]   = iss;
        mStall[k] = (rd != 0 && mPend[k] >= pUrg[k]) ? 1 : 0;
        if (iss != 0) begin
            mBank[k] = mPtr[k];
            mPtr[k]  = (mPtr[k] + 1) % NBANK;
        end
        if (rd == 0) mPend[k] = 0;
        else if (add != 0 && iss == 0 && mPend[k] == MAXP) mOvfl[k] = 1;
        else mPend[k] = mPend[k] + add - iss;
        if (rd == 0) begin
            mTmr[k] = 0; mTicks[k] = 0;
        end else if (pExt[k] == 0) begin
            if (add != 0) begin
                mTmr[k] = 0; mTicks[k]++;
            end else begin
                mTmr[k]++;
            end
        end
    endtask

    task automatic chkOutputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_d%0d_vld", tag, k), 32'(vldO[k]), mVld[k]);
            chk($sformatf("%s_d%0d_bank", tag, k), 32'(bankO[k]), mBank[k]);
            chk($sformatf("%s_d%0d_stall", tag, k), 32'(stallO[k]), mStall[k]);
            chk($sformatf("%s_d%0d_pend", tag, k), 32'(pendO[k]), mPend[k]);
            chk($sformatf("%s_d%0d_ovfl", tag, k), 32'(ovflO[k]), mOvfl[k]);
        end
    endtask

    // Called on a falling edge: outputs there reflect state of cycle 'cyc'.
    task automatic runCycle(input logic rd, input logic rf, input logic hd);
        chkOutputs($sformatf("c%0d", cyc));
        ready = rd; refr = rf; hold = hd;
        for (int k = 0; k < 3; k++) modelStep(k, int'(rd), int'(rf), int'(hd));
        @(negedge clk);
        cyc++;
    endtask

    task automatic asyncReset(input string tag);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_d%0d_vld", tag, k), 32'(vldO[k]), 0);
            chk($sformatf("%s_d%0d_bank", tag, k), 32'(bankO[k]), 0);
            chk($sformatf("%s_d%0d_stall", tag, k), 32'(stallO[k]), 0);
            chk($sformatf("%s_d%0d_pend", tag, k), 32'(pendO[k]), 0);
            chk($sformatf("%s_d%0d_ovfl", tag, k), 32'(ovflO[k]), 0);
        end
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b0; ready = 1'b0; refr = 1'b0; hold = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // Free-running timer, no datapath pressure.
        while (cyc < 40) begin
            if (cyc == 6)  chk("p1_A_vld6", 32'(vldO[0]), 0);
            if (cyc == 7)  chk("p1_A_vld7", 32'(vldO[0]), 1);
            if (cyc == 13) chk("p1_A_bank13", 32'(bankO[0]), 1);
            if (cyc == 31) chk("p1_A_vld31", 32'(vldO[0]), 1);
            if (cyc == 31) chk("p1_A_bank31", 32'(bankO[0]), 0);
            if (cyc == 13) chk("p1_B_vld13", 32'(vldO[1]), 0);
            if (cyc == 14) chk("p1_B_vld14", 32'(vldO[1]), 1);
            if (cyc == 27) chk("p1_B_vld27", 32'(vldO[1]), 1);
            runCycle(1'b1, 1'b0, 1'b0);
        end

        // Permanent hold builds backlog; external strobe saturates variant C.
        asyncReset("rst1");
        while (cyc < 26) begin
            if (cyc == 6)  chk("p2_A_pend6", 32'(pendO[0]), 1);
            if (cyc == 12) chk("p2_A_pend12", 32'(pendO[0]), 2);
            if (cyc == 18) chk("p2_A_pend18", 32'(pendO[0]), 3);
            if (cyc == 19) chk("p2_A_stall19", 32'(stallO[0]), 1);
            if (cyc == 20) chk("p2_A_vld20", 32'(vldO[0]), 1);
            if (cyc == 20) chk("p2_A_bank20", 32'(bankO[0]), 0);
            if (cyc == 21) chk("p2_A_bank21", 32'(bankO[0]), 1);
            if (cyc == 21) chk("p2_A_pend21", 32'(pendO[0]), 1);
            if (cyc == 21) chk("p2_A_stall21", 32'(stallO[0]), 0);
            if (cyc == 4)  chk("p2_C_pend4", 32'(pendO[2]), 4);
            if (cyc == 5)  chk("p2_C_ovfl5", 32'(ovflO[2]), 1);
            if (cyc == 6)  chk("p2_C_vld6", 32'(vldO[2]), 1);
            if (cyc == 8)  chk("p2_C_vld8", 32'(vldO[2]), 1);
            if (cyc == 8)  chk("p2_C_pend8", 32'(pendO[2]), 2);
            if (cyc == 8)  chk("p2_C_stall8", 32'(stallO[2]), 0);
            if (cyc == 25) chk("p2_C_ovfl25", 32'(ovflO[2]), 1);
            runCycle(1'b1, (cyc <= 5) ? 1'b1 : 1'b0, 1'b1);
        end

        // Randomised traffic with occasional ready drops and one mid-run reset.
        for (int i = 0; i < 900; i++) begin
            logic rd, rf, hd;
            rd = ($urandom_range(0, 24) != 0);
            rf = ($urandom_range(0, 9) < 4);
            hd = ($urandom_range(0, 3) != 0);
            if (i == 450) asyncReset("rst2");
            runCycle(rd, rf, hd);
        end
        chkOutputs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
